mult_accum: RTL

Downstream consumer for the 4x4 shift/add multiplier. It watches the multiplier's self-timed `Finish` level and samples the 8-bit product `O` once per multiply. It accumulates `N_TERMS` products into a saturating sum and presents the result on a valid/ready output port. It is the system-clock-domain boundary for the multiplier's two-phase clocking, so it contains the only synchronizer on that path.

---
 rtl/mult_pkg.sv | 14 +
 rtl/finish_sync_edge.sv | 24 ++
 rtl/mult_accum.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and state encoding
// for the multiplier accumulator slice.
package mult_pkg;

    localparam int PROD_W  = 8;
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/finish_sync_edge.sv
// finish_sync_edge: 2-flop synchronizer for a
// self-timed Finish level plus falling-edge pulse.
module finish_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic ev
);

    // sh[0], sh[1] synchronize; sh[2] is the edge reference
    logic [2:0] sh;

    // shift the asynchronous level through three stages
    always_ff @(posedge clk) begin
        if (reset) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], level};
        end
    end

    assign ev = ~sh[1] & sh[2];

endmodule

// File: rtl/mult_accum.sv
// mult_accum: accumulates N_TERMS multiplier products
// into a saturating sum behind a valid/ready port.
module mult_accum
    import mult_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int SUM_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mult_finish,
    input  logic [PROD_W-1:0]  mult_prod,
    input  logic               clear,
    input  logic               sum_ready,
    output logic               sum_valid,
    output logic [SUM_W-1:0]   sum,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] N_LAST =
        COUNT_W'(N_TERMS);
    localparam state_t LOAD_ST =
        (N_TERMS == 1) ? DONE : ACCUM;

    logic               ev;
    logic               accept;
    logic [COUNT_W-1:0] cnt_inc;
    logic [SUM_W:0]     wide;
    state_t             state;
    state_t             state_nx;

    finish_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .level (mult_finish),
        .ev    (ev)
    );

    assign accept  = (state == DONE) && sum_ready;
    assign cnt_inc = count + 1'b1;
    assign wide    = {1'b0, sum} + (SUM_W+1)'(mult_prod);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state; clear overrides events and accepts
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ev) state_nx = LOAD_ST;
                end
                ACCUM: begin
                    if (ev && cnt_inc == N_LAST)
                        state_nx = DONE;
                end
                DONE: begin
                    if (accept)
                        state_nx = ev ? LOAD_ST : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // result is presented whenever the FSM sits in DONE
    always_comb begin
        sum_valid = (state == DONE);
    end

    // sum, count and sticky flags
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ev) begin
                        sum   <= SUM_W'(mult_prod);
                        count <= COUNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (ev) begin
                        count <= cnt_inc;
                        if (wide[SUM_W]) begin
                            sum      <= '1;
                            overflow <= 1'b1;
                        end else begin
                            sum <= wide[SUM_W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (accept) begin
                        overflow <= 1'b0;
                        overrun  <= 1'b0;
                        if (ev) begin
                            sum   <= SUM_W'(mult_prod);
                            count <= COUNT_W'(1);
                        end else begin
                            sum   <= '0;
                            count <= '0;
                        end
                    end else if (ev) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    sum   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
